// File: rtl/iter_alu.sv
// iter_alu: registered ALU with single-cycle logic/arith/compare ops and
// iterative unsigned multiply/divide behind valid/ready handshakes.
module iter_alu #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 7
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   input  logic [3:0]       ALU_control,
   input  logic [2:0]       cmp_control,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             zero,
   output logic             cout,
   output logic             overflow
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010, OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111, OP_MUL = 4'b1000, OP_DIV = 4'b1001, OP_NOR = 4'b1100;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             div_q, div_d;
   logic [WIDTH-1:0] b_q, b_d, acc_q, acc_d, lo_q, lo_d, res_q, res_d, hi_q, hi_d;
   logic             zero_q, zero_d, cout_q, cout_d, ovf_q, ovf_d;

   logic [WIDTH-1:0] opb, sc_res, step_acc, step_lo;
   logic [WIDTH:0]   sum, mul_sum, div_r;
   logic             sub, is_add, lt, eq, cmp_bit, add_ovf, div_ge;

   assign in_ready  = state_q == IDLE && !rst_i;
   assign out_valid = state_q == DONE;
   assign result    = res_q;
   assign result_hi = hi_q;
   assign zero      = zero_q;
   assign cout      = cout_q;
   assign overflow  = ovf_q;

   always_comb begin
      sub     = ALU_control == OP_SUB;
      is_add  = sub || ALU_control == OP_ADD;
      opb     = sub ? ~src2 : src2;
      sum     = {1'b0, src1} + {1'b0, opb} + {{WIDTH{1'b0}}, sub};
      add_ovf = sum[WIDTH] ^ (sum[WIDTH-1] ^ src1[WIDTH-1] ^ opb[WIDTH-1]);
      lt      = $signed(src1) < $signed(src2);
      eq      = src1 == src2;
      cmp_bit = cmp_control[2] ? !cmp_control[1] && (cmp_control[0] ^ eq)
              : cmp_control[1] ? (cmp_control[0] ? !lt : lt || eq)
              : (cmp_control[0] ? !lt && !eq : lt);
      sc_res  = ALU_control == OP_AND ? src1 & src2
              : ALU_control == OP_OR  ? src1 | src2
              : ALU_control == OP_NOR ? ~(src1 | src2)
              : is_add                ? sum[WIDTH-1:0]
              : ALU_control == OP_SLT ? {{(WIDTH-1){1'b0}}, cmp_bit}
              : '0;
      // acc holds the running high product / partial remainder, lo the multiplier / quotient
      mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      div_r    = {acc_q, lo_q[WIDTH-1]};
      div_ge   = div_r >= {1'b0, b_q};
      step_acc = div_q ? (div_ge ? WIDTH'(div_r - {1'b0, b_q}) : div_r[WIDTH-1:0]) : mul_sum[WIDTH:1];
      step_lo  = div_q ? {lo_q[WIDTH-2:0], div_ge} : {mul_sum[0], lo_q[WIDTH-1:1]};
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      b_d     = b_q;
      acc_d   = acc_q;
      lo_d    = lo_q;
      res_d   = res_q;
      hi_d    = hi_q;
      zero_d  = zero_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: if (in_valid) begin
            if (ALU_control == OP_MUL || ALU_control == OP_DIV) begin
               div_d   = ALU_control == OP_DIV;
               b_d     = src2;
               lo_d    = src1;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = BUSY;
            end else begin
               res_d   = sc_res;
               hi_d    = '0;
               zero_d  = sc_res == '0;
               cout_d  = is_add && sum[WIDTH];
               ovf_d   = is_add && add_ovf;
               state_d = DONE;
            end
         end
         BUSY: begin
            acc_d = step_acc;
            lo_d  = step_lo;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               res_d   = step_lo;
               hi_d    = step_acc;
               zero_d  = step_lo == '0;
               cout_d  = 1'b0;
               ovf_d   = div_q && b_q == '0;
               state_d = DONE;
            end
         end
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         div_q   <= 1'b0;
         b_q     <= '0;
         acc_q   <= '0;
         lo_q    <= '0;
         res_q   <= '0;
         hi_q    <= '0;
         zero_q  <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         lo_q    <= lo_d;
         res_q   <= res_d;
         hi_q    <= hi_d;
         zero_q  <= zero_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end
endmodule

// File: tb/tb_iter_alu.sv
// tb_iter_alu: randomized and directed checks of iter_alu at WIDTH=32 and WIDTH=8
// against an arithmetic reference model.
module tb_iter_alu;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        in_valid, in_ready, out_valid, out_ready, zero, cout, overflow;
   logic [31:0] src1, src2, result, result_hi;
   logic [3:0]  op;
   logic [2:0]  cmp;

   logic        iv8, ir8, ov8, or8, z8, c8, v8;
   logic [7:0]  a8, b8, res8, hi8;
   logic [3:0]  op8;
   logic [2:0]  cmp8;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [63:0] res;
      logic [63:0] hi;
      logic        z;
      logic        c;
      logic        v;
   } exp_t;

   iter_alu #(.WIDTH(32), .CNT_W(7)) dut (
      .clk_i(clk), .rst_i(rst), .in_valid(in_valid), .in_ready(in_ready),
      .src1(src1), .src2(src2), .ALU_control(op), .cmp_control(cmp),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .result_hi(result_hi), .zero(zero), .cout(cout), .overflow(overflow));

   iter_alu #(.WIDTH(8), .CNT_W(4)) dut8 (
      .clk_i(clk), .rst_i(rst), .in_valid(iv8), .in_ready(ir8),
      .src1(a8), .src2(b8), .ALU_control(op8), .cmp_control(cmp8),
      .out_valid(ov8), .out_ready(or8), .result(res8),
      .result_hi(hi8), .zero(z8), .cout(c8), .overflow(v8));

   function automatic exp_t model(input logic [3:0] o, input logic [2:0] c,
                                  input logic [63:0] a_in, input logic [63:0] b_in, input int w);
      exp_t e;
      logic [63:0] mask, a, b;
      logic [64:0] full;
      longint sa, sb, sr, smax, smin;
      mask = (64'd1 << w) - 64'd1;
      a = a_in & mask;
      b = b_in & mask;
      sa = longint'(a);
      sb = longint'(b);
      if (a[w-1]) sa -= longint'(1) << w;
      if (b[w-1]) sb -= longint'(1) << w;
      smax = (longint'(1) << (w - 1)) - 1;
      smin = -(longint'(1) << (w - 1));
      e = '0;
      case (o)
         4'b0000: e.res = a & b;
         4'b0001: e.res = a | b;
         4'b1100: e.res = ~(a | b) & mask;
         4'b0010: begin
            full = {1'b0, a} + {1'b0, b};
            e.res = full[63:0] & mask;
            e.c = full[w];
            sr = sa + sb;
            e.v = sr > smax || sr < smin;
         end
         4'b0110: begin
            full = {1'b0, a} + {1'b0, ~b & mask} + 65'd1;
            e.res = full[63:0] & mask;
            e.c = full[w];
            sr = sa - sb;
            e.v = sr > smax || sr < smin;
         end
         4'b0111: case (c)
            3'd0: e.res = {63'd0, sa < sb};
            3'd1: e.res = {63'd0, sa > sb};
            3'd2: e.res = {63'd0, sa <= sb};
            3'd3: e.res = {63'd0, sa >= sb};
            3'd4: e.res = {63'd0, sa == sb};
            3'd5: e.res = {63'd0, sa != sb};
            default: e.res = '0;
         endcase
         4'b1000: begin
            full = {1'b0, a} * {1'b0, b};
            e.res = full[63:0] & mask;
            e.hi = (full[63:0] >> w) & mask;
         end
         4'b1001: begin
            if (b == 0) begin
               e.res = mask;
               e.hi = a;
               e.v = 1'b1;
            end else begin
               e.res = a / b;
               e.hi = a % b;
            end
         end
         default: e.res = '0;
      endcase
      e.z = e.res == 0;
      return e;
   endfunction

   task automatic run32(input logic [3:0] o, input logic [2:0] c, input logic [31:0] a,
                        input logic [31:0] b, input int hold, output exp_t got, output int lat);
      @(negedge clk);
      in_valid = 1'b1; op = o; cmp = c; src1 = a; src2 = b;
      @(negedge clk);
      in_valid = 1'b0; op = 4'($urandom); cmp = 3'($urandom); src1 = $urandom; src2 = $urandom;
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      repeat (hold) @(negedge clk);
      got = {32'd0, result, 32'd0, result_hi, zero, cout, overflow};
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic run8(input logic [3:0] o, input logic [2:0] c, input logic [7:0] a,
                       input logic [7:0] b, input int hold, output exp_t got, output int lat);
      @(negedge clk);
      iv8 = 1'b1; op8 = o; cmp8 = c; a8 = a; b8 = b;
      @(negedge clk);
      iv8 = 1'b0; op8 = 4'($urandom); cmp8 = 3'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
      lat = 1;
      while (!ov8 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      repeat (hold) @(negedge clk);
      got = {56'd0, res8, 56'd0, hi8, z8, c8, v8};
      or8 = 1'b1;
      @(negedge clk);
      or8 = 1'b0;
   endtask

   function automatic logic [3:0] rand_op();
      logic [3:0] ops [10] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
                               4'b1000, 4'b1001, 4'b1100, 4'b0011, 4'b1111};
      return ops[$urandom_range(0, 9)];
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({in_ready, out_valid, result, result_hi, zero, cout, overflow} !== '0) begin
         errors++;
         $display("FAIL reset32 got rdy=%b vld=%b res=%h hi=%h zcv=%b%b%b exp all 0",
                  in_ready, out_valid, result, result_hi, zero, cout, overflow);
      end
      checks++;
      if ({ir8, ov8, res8, hi8, z8, c8, v8} !== '0) begin
         errors++;
         $display("FAIL reset8 got rdy=%b vld=%b res=%h hi=%h exp all 0", ir8, ov8, res8, hi8);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || ir8 !== 1'b1) begin
         errors++;
         $display("FAIL reset_release got rdy32=%b rdy8=%b exp 1 1", in_ready, ir8);
      end
   endtask

   task automatic test_reset_mid_mul();
      exp_t got;
      int lat;
      bit seen;
      run32(4'b0010, 3'd0, 32'h12345678, 32'h1, 0, got, lat);
      @(negedge clk);
      in_valid = 1'b1; op = 4'b1000; src1 = 32'd7; src2 = 32'd9;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({in_ready, out_valid, result, result_hi, zero, cout, overflow} !== '0) begin
         errors++;
         $display("FAIL reset_mid_mul got vld=%b res=%h hi=%h zcv=%b%b%b exp all 0",
                  out_valid, result, result_hi, zero, cout, overflow);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_mul_ready got %b exp 1", in_ready);
      end
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL reset_mid_mul_stale got out_valid=1 exp 0");
      end
   endtask

   task automatic test_add_sub();
      exp_t got, e;
      int lat;
      logic [31:0] a, b;
      logic [3:0] o;
      run32(4'b0010, 3'd0, 32'h7FFFFFFF, 32'h1, 0, got, lat);
      checks++;
      if (got.res !== 64'h80000000 || got.v !== 1'b1 || got.c !== 1'b0 || got.z !== 1'b0 || lat !== 1) begin
         errors++;
         $display("FAIL add_ovf got res=%h v=%b c=%b z=%b lat=%0d exp 80000000 1 0 0 1",
                  got.res, got.v, got.c, got.z, lat);
      end
      run32(4'b0110, 3'd0, 32'd5, 32'd5, 0, got, lat);
      checks++;
      if (got.res !== 64'h0 || got.z !== 1'b1 || got.c !== 1'b1 || got.v !== 1'b0 || lat !== 1) begin
         errors++;
         $display("FAIL sub_zero got res=%h z=%b c=%b v=%b lat=%0d exp 0 1 1 0 1",
                  got.res, got.z, got.c, got.v, lat);
      end
      repeat (20) begin
         o = $urandom_range(0, 1) ? 4'b0010 : 4'b0110;
         a = $urandom_range(0, 3) == 0 ? 32'h80000000 : $urandom;
         b = $urandom_range(0, 3) == 0 ? 32'hFFFFFFFF : $urandom;
         e = model(o, 3'd0, {32'd0, a}, {32'd0, b}, 32);
         run32(o, 3'd0, a, b, 0, got, lat);
         checks++;
         if (got !== e || lat !== 1) begin
            errors++;
            $display("FAIL addsub op=%h a=%h b=%h got res=%h zcv=%b%b%b lat=%0d exp res=%h zcv=%b%b%b lat=1",
                     o, a, b, got.res, got.z, got.c, got.v, lat, e.res, e.z, e.c, e.v);
         end
      end
   endtask

   task automatic test_slt();
      exp_t got, e;
      int lat;
      logic [2:0] cmps [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
      logic [31:0] exps [8] = '{32'd1, 32'd0, 32'd1, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0};
      logic [31:0] a, b;
      logic [2:0] c;
      for (int i = 0; i < 8; i++) begin
         run32(4'b0111, cmps[i], 32'hFFFFFFFF, 32'd1, 0, got, lat);
         checks++;
         if (got.res !== {32'd0, exps[i]} || got.hi !== 64'd0) begin
            errors++;
            $display("FAIL slt_matrix cmp=%b got %h exp %h", cmps[i], got.res, exps[i]);
         end
      end
      repeat (16) begin
         a = $urandom;
         b = $urandom_range(0, 2) == 0 ? a : $urandom;
         c = 3'($urandom);
         e = model(4'b0111, c, {32'd0, a}, {32'd0, b}, 32);
         run32(4'b0111, c, a, b, 0, got, lat);
         checks++;
         if (got !== e || lat !== 1) begin
            errors++;
            $display("FAIL slt cmp=%b a=%h b=%h got res=%h lat=%0d exp res=%h lat=1", c, a, b, got.res, lat, e.res);
         end
      end
   endtask

   task automatic test_logic();
      exp_t got, e;
      int lat;
      logic [3:0] ops [6] = '{4'b0000, 4'b0001, 4'b1100, 4'b0011, 4'b1111, 4'b1010};
      logic [31:0] a, b;
      logic [3:0] o;
      repeat (18) begin
         o = ops[$urandom_range(0, 5)];
         a = $urandom;
         b = $urandom_range(0, 3) == 0 ? ~a : $urandom;
         e = model(o, 3'd0, {32'd0, a}, {32'd0, b}, 32);
         run32(o, 3'd0, a, b, 0, got, lat);
         checks++;
         if (got !== e || lat !== 1) begin
            errors++;
            $display("FAIL logic op=%h a=%h b=%h got res=%h hi=%h z=%b lat=%0d exp res=%h hi=%h z=%b",
                     o, a, b, got.res, got.hi, got.z, lat, e.res, e.hi, e.z);
         end
      end
   endtask

   task automatic test_mul();
      exp_t got, e;
      int lat;
      bit bad_ready;
      logic [31:0] a, b;
      @(negedge clk);
      in_valid = 1'b1; op = 4'b1000; src1 = 32'hFFFFFFFF; src2 = 32'hFFFFFFFF;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      bad_ready = 1'b0;
      while (!out_valid && lat < 100) begin
         if (in_ready !== 1'b0) bad_ready = 1'b1;
         in_valid = 1'($urandom_range(0, 1)); op = 4'b0010; src1 = $urandom; src2 = $urandom;
         @(negedge clk);
         lat++;
      end
      in_valid = 1'b0;
      checks++;
      if (result_hi !== 32'hFFFFFFFE || result !== 32'h1 || cout !== 1'b0 || overflow !== 1'b0 || lat !== 33) begin
         errors++;
         $display("FAIL mul_full got hi=%h lo=%h c=%b v=%b lat=%0d exp FFFFFFFE 00000001 0 0 33",
                  result_hi, result, cout, overflow, lat);
      end
      checks++;
      if (bad_ready) begin
         errors++;
         $display("FAIL mul_busy_ready got in_ready=1 during BUSY exp 0");
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      repeat (8) begin
         a = $urandom_range(0, 3) == 0 ? 32'd0 : $urandom;
         b = $urandom;
         e = model(4'b1000, 3'd0, {32'd0, a}, {32'd0, b}, 32);
         run32(4'b1000, 3'd0, a, b, $urandom_range(0, 2), got, lat);
         checks++;
         if (got !== e || lat !== 33) begin
            errors++;
            $display("FAIL mul a=%h b=%h got hi=%h lo=%h z=%b lat=%0d exp hi=%h lo=%h z=%b lat=33",
                     a, b, got.hi, got.res, got.z, lat, e.hi, e.res, e.z);
         end
      end
   endtask

   task automatic test_div();
      exp_t got, e;
      int lat;
      logic [31:0] a, b;
      run32(4'b1001, 3'd0, 32'd100, 32'd7, 0, got, lat);
      checks++;
      if (got.res !== 64'd14 || got.hi !== 64'd2 || got.v !== 1'b0 || lat !== 33) begin
         errors++;
         $display("FAIL div_100_7 got q=%0d r=%0d v=%b lat=%0d exp 14 2 0 33", got.res, got.hi, got.v, lat);
      end
      run32(4'b1001, 3'd0, 32'd100, 32'd0, 0, got, lat);
      checks++;
      if (got.res !== 64'hFFFFFFFF || got.hi !== 64'd100 || got.v !== 1'b1 || lat !== 33) begin
         errors++;
         $display("FAIL div_by_zero got q=%h r=%0d v=%b lat=%0d exp FFFFFFFF 100 1 33", got.res, got.hi, got.v, lat);
      end
      repeat (10) begin
         a = $urandom;
         case ($urandom_range(0, 3))
            0: b = 32'd0;
            1: b = 32'($urandom_range(1, 255));
            2: b = a;
            default: b = $urandom;
         endcase
         e = model(4'b1001, 3'd0, {32'd0, a}, {32'd0, b}, 32);
         run32(4'b1001, 3'd0, a, b, 0, got, lat);
         checks++;
         if (got !== e || lat !== 33) begin
            errors++;
            $display("FAIL div a=%h b=%h got q=%h r=%h zv=%b%b lat=%0d exp q=%h r=%h zv=%b%b lat=33",
                     a, b, got.res, got.hi, got.z, got.v, lat, e.res, e.hi, e.z, e.v);
         end
      end
   endtask

   task automatic test_backpressure();
      int lat;
      bit bad;
      @(negedge clk);
      in_valid = 1'b1; op = 4'b0010; src1 = 32'd3; src2 = 32'd4;
      @(negedge clk);
      in_valid = 1'b0; src1 = $urandom; src2 = $urandom;
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      bad = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (out_valid !== 1'b1 || result !== 32'd7 || in_ready !== 1'b0) bad = 1'b1;
         in_valid = 1'b1; op = 4'b0000;
         @(negedge clk);
      end
      in_valid = 1'b0;
      checks++;
      if (bad || lat !== 1) begin
         errors++;
         $display("FAIL backpressure_hold got vld=%b res=%0d rdy=%b lat=%0d exp 1 7 0 1", out_valid, result, in_ready, lat);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL backpressure_release got rdy=%b vld=%b exp 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_back_to_back();
      exp_t got, e;
      int lat;
      logic [31:0] a, b;
      logic [3:0] o;
      logic [2:0] c;
      repeat (24) begin
         o = rand_op();
         c = 3'($urandom);
         a = $urandom;
         b = $urandom_range(0, 5) == 0 ? 32'd0 : $urandom;
         e = model(o, c, {32'd0, a}, {32'd0, b}, 32);
         run32(o, c, a, b, $urandom_range(0, 2), got, lat);
         checks++;
         if (got !== e || lat !== ((o == 4'b1000 || o == 4'b1001) ? 33 : 1)) begin
            errors++;
            $display("FAIL b2b op=%h cmp=%b a=%h b=%h got res=%h hi=%h zcv=%b%b%b lat=%0d exp res=%h hi=%h zcv=%b%b%b",
                     o, c, a, b, got.res, got.hi, got.z, got.c, got.v, lat, e.res, e.hi, e.z, e.c, e.v);
         end
      end
   endtask

   task automatic test_width8();
      exp_t got, e;
      int lat;
      logic [7:0] a, b;
      logic [3:0] o;
      logic [2:0] c;
      run8(4'b1000, 3'd0, 8'hFF, 8'hFF, 0, got, lat);
      checks++;
      if (got.hi !== 64'hFE || got.res !== 64'h01 || lat !== 9) begin
         errors++;
         $display("FAIL w8_mul_full got hi=%h lo=%h lat=%0d exp FE 01 9", got.hi, got.res, lat);
      end
      run8(4'b1001, 3'd0, 8'd100, 8'd0, 0, got, lat);
      checks++;
      if (got.res !== 64'hFF || got.hi !== 64'd100 || got.v !== 1'b1 || lat !== 9) begin
         errors++;
         $display("FAIL w8_div_zero got q=%h r=%0d v=%b lat=%0d exp FF 100 1 9", got.res, got.hi, got.v, lat);
      end
      run8(4'b0010, 3'd0, 8'h7F, 8'h01, 0, got, lat);
      checks++;
      if (got.res !== 64'h80 || got.v !== 1'b1 || got.c !== 1'b0 || lat !== 1) begin
         errors++;
         $display("FAIL w8_add_ovf got res=%h v=%b c=%b lat=%0d exp 80 1 0 1", got.res, got.v, got.c, lat);
      end
      repeat (30) begin
         o = rand_op();
         c = 3'($urandom);
         a = 8'($urandom);
         b = $urandom_range(0, 5) == 0 ? 8'd0 : 8'($urandom);
         e = model(o, c, {56'd0, a}, {56'd0, b}, 8);
         run8(o, c, a, b, $urandom_range(0, 1), got, lat);
         checks++;
         if (got !== e || lat !== ((o == 4'b1000 || o == 4'b1001) ? 9 : 1)) begin
            errors++;
            $display("FAIL w8 op=%h cmp=%b a=%h b=%h got res=%h hi=%h zcv=%b%b%b lat=%0d exp res=%h hi=%h zcv=%b%b%b",
                     o, c, a, b, got.res, got.hi, got.z, got.c, got.v, lat, e.res, e.hi, e.z, e.c, e.v);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0; out_ready = 1'b0; op = '0; cmp = '0; src1 = '0; src2 = '0;
      iv8 = 1'b0; or8 = 1'b0; op8 = '0; cmp8 = '0; a8 = '0; b8 = '0;
      test_reset();
      test_reset_mid_mul();
      test_add_sub();
      test_slt();
      test_logic();
      test_mul();
      test_div();
      test_backpressure();
      test_back_to_back();
      test_width8();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
